// File: rtl/cmos_pkg.sv
// cmos_pkg: shared widths, limits and the pixel-with-flags record for the DVP pixel packer
package cmos_pkg;
  localparam int FRAME_CNT_W = 16;
  localparam int MAX_BPP = 4;
  localparam int MAX_PIX_W = 64;
  function automatic int out_w(input int in_w, input int bpp);
    return in_w * bpp;
  endfunction
  typedef struct packed {
    logic [MAX_PIX_W-1:0] data;
    logic                 sof;
    logic                 eol;
  } pix_t;
endpackage

// File: rtl/cmos_sync_edge.sv
// cmos_sync_edge: registers vsync/href and flags the frame-start edge and the line end
// pclk/rst: clock and async active-high reset
// vs_i/de_i: raw sensor vsync and href
// frame_edge_o: vs_i reached VS_POL this cycle; line_end_o: de_i fell this cycle
module cmos_sync_edge #(
  parameter bit VS_POL = 1'b1
) (
  input  logic pclk,
  input  logic rst,
  input  logic vs_i,
  input  logic de_i,
  output logic frame_edge_o,
  output logic line_end_o
);
  logic vs_q, de_q;
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= vs_i;
      de_q <= de_i;
    end
  assign frame_edge_o = (vs_q != VS_POL) && (vs_i == VS_POL);
  assign line_end_o = de_q && !de_i;
endmodule

// File: rtl/cmos_pixel_packer.sv
// cmos_pixel_packer: packs BYTES_PER_PIX sensor beats into one pixel tagged with sof/eol
// pclk/rst: clock and async active-high reset; cfg_swap: 1 puts the first beat at the LSBs
// vs_i/de_i/pdata_i: DVP capture inputs
// pix_vld_o/pix_sof_o/pix_eol_o/pdata_o: registered pixel stream
// line_pix_cnt_o: pixels in the last closed line; frag_err_o: partial pixel dropped; frame_cnt_o: frames started
module cmos_pixel_packer
  import cmos_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter bit VS_POL = 1'b1,
  parameter int H_CNT_W = 12,
  localparam int OUT_W = out_w(IN_W, BYTES_PER_PIX)
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   cfg_swap,
  input  logic                   vs_i,
  input  logic                   de_i,
  input  logic [IN_W-1:0]        pdata_i,
  output logic                   pix_vld_o,
  output logic                   pix_sof_o,
  output logic                   pix_eol_o,
  output logic [OUT_W-1:0]       pdata_o,
  output logic [H_CNT_W-1:0]     line_pix_cnt_o,
  output logic                   frag_err_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);
  localparam int IDX_W = $clog2(MAX_BPP);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_PER_PIX - 1);
  logic fe, le, beat, done, flush, emit, swap;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic swap_q;
  logic [OUT_W-1:0] acc_q, acc_d, hold_data_q, hold_data_d;
  logic hold_vld_q, hold_vld_d, hold_sof_q, hold_sof_d, sof_pend_q, sof_pend_d;
  logic [H_CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic vld_q, vld_d, frag_q, frag_d;
  pix_t out_q, out_d;
  cmos_sync_edge #(.VS_POL(VS_POL)) u_edge (
    .pclk(pclk), .rst(rst), .vs_i(vs_i), .de_i(de_i),
    .frame_edge_o(fe), .line_end_o(le)
  );
  assign beat = de_i && !fe;
  assign done = beat && (idx_q == LAST);
  assign flush = fe || le;
  assign emit = hold_vld_q && (done || flush);
  // byte order is frozen by the first beat so one pixel never mixes orders
  assign swap = (idx_q == '0) ? cfg_swap : swap_q;
  always_comb begin
    acc_d = acc_q;
    if (beat) acc_d[(swap ? int'(idx_q) : BYTES_PER_PIX - 1 - int'(idx_q)) * IN_W +: IN_W] = pdata_i;
    idx_d = (flush || done) ? '0 : beat ? idx_q + 1'b1 : idx_q;
    hold_data_d = done ? acc_d : hold_data_q;
    hold_sof_d = done ? sof_pend_q : hold_sof_q;
    hold_vld_d = done ? 1'b1 : flush ? 1'b0 : hold_vld_q;
    sof_pend_d = fe ? 1'b1 : done ? 1'b0 : sof_pend_q;
    hcnt_d = flush ? '0 : (done && !(&hcnt_q)) ? hcnt_q + 1'b1 : hcnt_q;
    lcnt_d = flush ? hcnt_q : lcnt_q;
    frag_d = flush && (idx_q != '0);
    fcnt_d = fcnt_q + FRAME_CNT_W'(fe);
    vld_d = emit;
    out_d = emit ? pix_t'{data: MAX_PIX_W'(hold_data_q), sof: hold_sof_q, eol: flush}
                 : pix_t'{data: out_q.data, sof: 1'b0, eol: 1'b0};
  end
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      idx_q <= '0;
      swap_q <= 1'b0;
      acc_q <= '0;
      hold_data_q <= '0;
      hold_sof_q <= 1'b0;
      hold_vld_q <= 1'b0;
      sof_pend_q <= 1'b0;
      hcnt_q <= '0;
      lcnt_q <= '0;
      fcnt_q <= '0;
      vld_q <= 1'b0;
      frag_q <= 1'b0;
      out_q <= '0;
    end else begin
      idx_q <= idx_d;
      swap_q <= swap;
      acc_q <= acc_d;
      hold_data_q <= hold_data_d;
      hold_sof_q <= hold_sof_d;
      hold_vld_q <= hold_vld_d;
      sof_pend_q <= sof_pend_d;
      hcnt_q <= hcnt_d;
      lcnt_q <= lcnt_d;
      fcnt_q <= fcnt_d;
      vld_q <= vld_d;
      frag_q <= frag_d;
      out_q <= out_d;
    end
  assign pix_vld_o = vld_q;
  assign pix_sof_o = out_q.sof;
  assign pix_eol_o = out_q.eol;
  assign pdata_o = OUT_W'(out_q >> 2);
  assign line_pix_cnt_o = lcnt_q;
  assign frag_err_o = frag_q;
  assign frame_cnt_o = fcnt_q;
endmodule

// File: tb/tb_cmos_pixel_packer.sv
// tb_cmos_pixel_packer: two packers (2 and 3 beats per pixel) against a line-level reference model
module tb_cmos_pixel_packer;
  logic clk = 1'b0, rst = 1'b1, cfg_swap = 1'b0, vs = 1'b0, de = 1'b0;
  logic [7:0] pd = '0;
  always #5 clk = ~clk;
  logic vld0, sof0, eol0, frag0, vld1, sof1, eol1, frag1;
  logic [15:0] pdo0, fc0, fc1;
  logic [23:0] pdo1;
  logic [11:0] lc0, lc1;
  cmos_pixel_packer #(.BYTES_PER_PIX(2)) dut0 (
    .pclk(clk), .rst(rst), .cfg_swap(cfg_swap), .vs_i(vs), .de_i(de), .pdata_i(pd),
    .pix_vld_o(vld0), .pix_sof_o(sof0), .pix_eol_o(eol0), .pdata_o(pdo0),
    .line_pix_cnt_o(lc0), .frag_err_o(frag0), .frame_cnt_o(fc0));
  cmos_pixel_packer #(.BYTES_PER_PIX(3)) dut1 (
    .pclk(clk), .rst(rst), .cfg_swap(cfg_swap), .vs_i(vs), .de_i(de), .pdata_i(pd),
    .pix_vld_o(vld1), .pix_sof_o(sof1), .pix_eol_o(eol1), .pdata_o(pdo1),
    .line_pix_cnt_o(lc1), .frag_err_o(frag1), .frame_cnt_o(fc1));
  typedef struct {logic [31:0] data; logic sof; logic eol; int cyc;} ev_t;
  ev_t mq[2][$];
  ev_t eq[2][$];
  int fragn[2], frag_cyc[2], exp_frag[2], exp_lcnt[2];
  bit sof_pend_m[2];
  int exp_fcnt = 0, checks = 0, errors = 0, cyc = 0, last_beat_cyc = 0, de_low_cyc = 0;
  function automatic ev_t mk(input logic [31:0] dt, input logic s, input logic e, input int c);
    ev_t r;
    r.data = dt; r.sof = s; r.eol = e; r.cyc = c;
    return r;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (vld0) mq[0].push_back(mk(32'(pdo0), sof0, eol0, cyc));
    if (vld1) mq[1].push_back(mk(32'(pdo1), sof1, eol1, cyc));
    if (frag0) begin fragn[0]++; frag_cyc[0] = cyc; end
    if (frag1) begin fragn[1]++; frag_cyc[1] = cyc; end
  end
  // reference: a line is cut into whole pixels, any leftover beats are a fragment
  task automatic add_line(input int d, input logic [7:0] b[$], input bit swap);
    int bpp, np;
    logic [31:0] v;
    bpp = d ? 3 : 2;
    np = b.size() / bpp;
    for (int j = 0; j < np; j++) begin
      v = '0;
      for (int k = 0; k < bpp; k++)
        v = swap ? v | (32'(b[j*bpp+k]) << (8*k)) : (v << 8) | 32'(b[j*bpp+k]);
      eq[d].push_back(mk(v, sof_pend_m[d] && j == 0, j == np - 1, 0));
    end
    if (np > 0) sof_pend_m[d] = 1'b0;
    if (b.size() % bpp != 0) exp_frag[d]++;
    exp_lcnt[d] = np;
  endtask
  task automatic frame_edge_m();
    sof_pend_m[0] = 1'b1;
    sof_pend_m[1] = 1'b1;
    exp_fcnt++;
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete(); eq[d].delete();
      fragn[d] = 0; exp_frag[d] = 0; exp_lcnt[d] = 0; sof_pend_m[d] = 1'b0;
    end
    exp_fcnt = 0;
  endtask
  task automatic beat(input logic [7:0] b);
    @(posedge clk); #1 de = 1'b1; pd = b;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1 de = 1'b0; pd = 8'($urandom); end
  endtask
  task automatic vs_pulse();
    @(posedge clk); #1 vs = 1'b1; de = 1'b0;
    @(posedge clk); #1 vs = 1'b0;
    frame_edge_m();
    exp_lcnt[0] = 0;
    exp_lcnt[1] = 0;
    idle(1);
  endtask
  task automatic send_line(input logic [7:0] b[$], input bit swap);
    cfg_swap = swap;
    foreach (b[i]) beat(b[i]);
    last_beat_cyc = cyc;
    idle(1);
    de_low_cyc = cyc;
    idle(2);
    add_line(0, b, swap);
    add_line(1, b, swap);
  endtask
  task automatic vs_mid_line(input logic [7:0] a[$], input logic [7:0] b[$], input bit swap);
    cfg_swap = swap;
    foreach (a[i]) beat(a[i]);
    @(posedge clk); #1 vs = 1'b1; de = 1'b1; pd = 8'($urandom);
    add_line(0, a, swap);
    add_line(1, a, swap);
    frame_edge_m();
    send_line(b, swap);
    vs = 1'b0;
  endtask
  task automatic check_all(input string name);
    int lc;
    for (int d = 0; d < 2; d++) begin
      lc = d ? int'(lc1) : int'(lc0);
      checks++;
      if (mq[d].size() != eq[d].size()) begin
        errors++;
        $display("FAIL %s dut%0d pixel count got %0d want %0d", name, d, mq[d].size(), eq[d].size());
      end
      for (int i = 0; i < mq[d].size() && i < eq[d].size(); i++) begin
        checks++;
        if (mq[d][i].data !== eq[d][i].data || mq[d][i].sof !== eq[d][i].sof || mq[d][i].eol !== eq[d][i].eol) begin
          errors++;
          $display("FAIL %s dut%0d pix%0d got %h sof%b eol%b want %h sof%b eol%b", name, d, i,
                   mq[d][i].data, mq[d][i].sof, mq[d][i].eol, eq[d][i].data, eq[d][i].sof, eq[d][i].eol);
        end
      end
      checks++;
      if (fragn[d] != exp_frag[d]) begin
        errors++;
        $display("FAIL %s dut%0d frag pulses got %0d want %0d", name, d, fragn[d], exp_frag[d]);
      end
      checks++;
      if (lc != exp_lcnt[d]) begin
        errors++;
        $display("FAIL %s dut%0d line_pix_cnt got %0d want %0d", name, d, lc, exp_lcnt[d]);
      end
      mq[d].delete(); eq[d].delete();
      fragn[d] = 0; exp_frag[d] = 0;
    end
    checks++;
    if (int'(fc0) != exp_fcnt || int'(fc1) != exp_fcnt) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d/%0d want %0d", name, fc0, fc1, exp_fcnt);
    end
  endtask
  task automatic chk_zero(input string name);
    checks++;
    if ({vld0, sof0, eol0, frag0, pdo0, lc0, fc0} !== '0) begin
      errors++;
      $display("FAIL %s dut0 outputs got %h want 0", name, {vld0, sof0, eol0, frag0, pdo0, lc0, fc0});
    end
    checks++;
    if ({vld1, sof1, eol1, frag1, pdo1, lc1, fc1} !== '0) begin
      errors++;
      $display("FAIL %s dut1 outputs got %h want 0", name, {vld1, sof1, eol1, frag1, pdo1, lc1, fc1});
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    idle(2);
  endtask
  task automatic test_basic(input bit swap);
    vs_pulse();
    send_line('{8'h12, 8'h34, 8'h56, 8'h78}, swap);
    checks++;
    if (mq[0].size() != 2 || mq[0][0].data !== (swap ? 32'h3412 : 32'h1234) || mq[0][1].data !== (swap ? 32'h7856 : 32'h5678)
        || mq[0][0].sof !== 1'b1 || mq[0][1].eol !== 1'b1) begin
      errors++;
      $display("FAIL basic_swap%0d pixels got %h %h want %h %h", swap, mq[0][0].data, mq[0][1].data,
               swap ? 32'h3412 : 32'h1234, swap ? 32'h7856 : 32'h5678);
    end
    checks++;
    if (mq[0][0].cyc != last_beat_cyc + 1 || mq[0][1].cyc != de_low_cyc + 1) begin
      errors++;
      $display("FAIL basic_latency cycles got %0d %0d want %0d %0d", mq[0][0].cyc, mq[0][1].cyc, last_beat_cyc + 1, de_low_cyc + 1);
    end
    check_all(swap ? "basic_swap1" : "basic_swap0");
  endtask
  task automatic test_frag();
    send_line('{8'hAA, 8'hBB, 8'hCC}, 1'b0);
    checks++;
    if (fragn[0] != 1 || frag_cyc[0] != de_low_cyc + 1 || mq[0].size() != 1 || mq[0][0].cyc != frag_cyc[0]) begin
      errors++;
      $display("FAIL frag_timing got frag %0d at %0d pix at %0d want 1 at %0d", fragn[0], frag_cyc[0], mq[0][0].cyc, de_low_cyc + 1);
    end
    check_all("frag");
  endtask
  task automatic test_bpp3();
    send_line('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b0);
    checks++;
    if (mq[1].size() != 2 || mq[1][0].data !== 32'h010203 || mq[1][1].data !== 32'h040506 || mq[1][1].eol !== 1'b1) begin
      errors++;
      $display("FAIL bpp3_values got %h %h want 010203 040506", mq[1][0].data, mq[1][1].data);
    end
    check_all("bpp3");
  endtask
  task automatic test_vs_mid_line();
    vs_pulse();
    vs_mid_line('{8'h11, 8'h22, 8'h33}, '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99}, 1'b0);
    check_all("vs_mid_line");
  endtask
  task automatic test_reset_mid_pixel();
    logic [7:0] q[$];
    vs_pulse();
    beat(8'h5A); beat(8'hA5); beat(8'h3C);
    @(posedge clk); #3 rst = 1'b1; de = 1'b0;
    #1 chk_zero("reset_mid_pixel");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    idle(1);
    repeat (5) q.push_back(8'($urandom));
    send_line(q, 1'b0);
    check_all("after_reset");
  endtask
  task automatic test_random();
    logic [7:0] q[$], r[$];
    for (int f = 0; f < 4; f++) begin
      vs_pulse();
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        q = {};
        repeat ($urandom_range(1, 9)) q.push_back(8'($urandom));
        send_line(q, 1'($urandom_range(0, 1)));
      end
      if (f == 2) begin
        q = {}; r = {};
        repeat ($urandom_range(1, 5)) q.push_back(8'($urandom));
        repeat ($urandom_range(1, 7)) r.push_back(8'($urandom));
        vs_mid_line(q, r, 1'($urandom_range(0, 1)));
      end
      check_all($sformatf("random_frame%0d", f));
    end
  endtask
  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_frag();
    test_bpp3();
    test_vs_mid_line();
    test_reset_mid_pixel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
